// File: rtl/dca_matrix_store_from_mreg.sv
// dca_matrix_store_from_mreg
//   Streams the rows of a filled DCA matrix register (mreg) out as tensor rows
//   with a valid/ready/last handshake. Only the first num_row rows are emitted.
//   The remaining padded rows are then drained, so that the mreg is empty and
//   realigned for the next matrix.
//
// Ports
//   clk, rstnn                 clock, asynchronous active-low reset
//   clear                      synchronous abort to IDLE (priority over enable)
//   enable                     advances FSM and row counter; low = hold
//   busy                       high when not IDLE
//   store_num_row_m1           rows to emit minus 1, sampled at accept
//   storereg_wrequest/wready   producer hands over a full mreg
//   mreg_move_renable          pop the mreg head row
//   mreg_move_rdata_list1d     current mreg head row
//   store_tensor_row_r*        outgoing row stream (valid/ready/last/data)
//   store_num_col_m1           columns to keep minus 1 (macro build only)
//
// Build option
//   DCA_MATRIX_STORE_COL_MASK_EN: adds store_num_col_m1. It is latched at accept,
//   and in SEND the columns above it are replaced with TENSOR_ZERO.

module dca_matrix_store_from_mreg #(
   parameter int MATRIX_SIZE_PARA = 4,
   parameter int TENSOR_PARA      = 0,
   localparam int MATRIX_NUM_ROW   = MATRIX_SIZE_PARA,
   localparam int MATRIX_NUM_COL   = MATRIX_SIZE_PARA,
   localparam int BW_TENSOR_SCALAR = (TENSOR_PARA == 1) ? 16 : (TENSOR_PARA == 2) ? 32 : 8,
   localparam int BW_TENSOR_ROW    = MATRIX_NUM_COL * BW_TENSOR_SCALAR,
   localparam int BW_ROW_INDEX     = (MATRIX_NUM_ROW > 1) ? $clog2(MATRIX_NUM_ROW) : 1,
   localparam int BW_COL_INDEX     = (MATRIX_NUM_COL > 1) ? $clog2(MATRIX_NUM_COL) : 1
) (
   input  logic                     clk,
   input  logic                     rstnn,
   input  logic                     clear,
   input  logic                     enable,
   output logic                     busy,
   input  logic [BW_ROW_INDEX-1:0]  store_num_row_m1,
`ifdef DCA_MATRIX_STORE_COL_MASK_EN
   input  logic [BW_COL_INDEX-1:0]  store_num_col_m1,
`endif
   input  logic                     storereg_wrequest,
   output logic                     storereg_wready,
   output logic                     mreg_move_renable,
   input  logic [BW_TENSOR_ROW-1:0] mreg_move_rdata_list1d,
   output logic                     store_tensor_row_rvalid,
   output logic                     store_tensor_row_rlast,
   output logic [BW_TENSOR_ROW-1:0] store_tensor_row_rdata,
   input  logic                     store_tensor_row_rready
);

   localparam logic [BW_TENSOR_SCALAR-1:0] TENSOR_ZERO = '0;
   localparam logic [BW_ROW_INDEX-1:0]     ROW_LAST    = BW_ROW_INDEX'(MATRIX_NUM_ROW - 1);

   typedef enum logic [1:0] {IDLE, SEND, DRAIN} state_t;

   state_t                    state, state_next;
   logic [BW_ROW_INDEX-1:0]   cnt, cnt_next;
   logic [BW_ROW_INDEX-1:0]   num_m1, num_m1_next;
   logic [BW_ROW_INDEX-1:0]   num_row_clamped;
   logic [BW_TENSOR_ROW-1:0]  head_masked;
   logic                      fire;

   // The clamp is only needed when the index field can encode values past N-1.
   generate
      if ((1 << BW_ROW_INDEX) > MATRIX_NUM_ROW) begin : g_row_clamp
         assign num_row_clamped = (store_num_row_m1 > ROW_LAST) ? ROW_LAST : store_num_row_m1;
      end else begin : g_row_pass
         assign num_row_clamped = store_num_row_m1;
      end
   endgenerate

`ifdef DCA_MATRIX_STORE_COL_MASK_EN
   localparam logic [BW_COL_INDEX-1:0] COL_LAST = BW_COL_INDEX'(MATRIX_NUM_COL - 1);
   logic [BW_COL_INDEX-1:0] col_m1, col_m1_next, num_col_clamped;

   generate
      if ((1 << BW_COL_INDEX) > MATRIX_NUM_COL) begin : g_col_clamp
         assign num_col_clamped = (store_num_col_m1 > COL_LAST) ? COL_LAST : store_num_col_m1;
      end else begin : g_col_pass
         assign num_col_clamped = store_num_col_m1;
      end
   endgenerate

   always_comb begin
      head_masked = mreg_move_rdata_list1d;
      for (int unsigned c = 0; c < MATRIX_NUM_COL; c++) begin
         if (c > 32'(col_m1)) head_masked[c*BW_TENSOR_SCALAR +: BW_TENSOR_SCALAR] = TENSOR_ZERO;
      end
   end
`else
   assign head_masked = mreg_move_rdata_list1d;
`endif

   // State register
   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) begin
         state  <= IDLE;
         cnt    <= '0;
         num_m1 <= '0;
`ifdef DCA_MATRIX_STORE_COL_MASK_EN
         col_m1 <= '0;
`endif
      end else begin
         state  <= state_next;
         cnt    <= cnt_next;
         num_m1 <= num_m1_next;
`ifdef DCA_MATRIX_STORE_COL_MASK_EN
         col_m1 <= col_m1_next;
`endif
      end
   end

   // Next-state logic
   always_comb begin
      state_next  = state;
      cnt_next    = cnt;
      num_m1_next = num_m1;
`ifdef DCA_MATRIX_STORE_COL_MASK_EN
      col_m1_next = col_m1;
`endif
      if (clear) begin
         state_next = IDLE;
         cnt_next   = '0;
      end else if (enable) begin
         case (state)
            IDLE: begin
               if (storereg_wrequest) begin
                  state_next  = SEND;
                  cnt_next    = '0;
                  num_m1_next = num_row_clamped;
`ifdef DCA_MATRIX_STORE_COL_MASK_EN
                  col_m1_next = num_col_clamped;
`endif
               end
            end
            SEND: begin
               if (fire) begin
                  if (cnt == num_m1) begin
                     // Last emitted row: skip DRAIN when the mreg is already empty.
                     if (cnt == ROW_LAST) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                     end else begin
                        state_next = DRAIN;
                        cnt_next   = cnt + BW_ROW_INDEX'(1);
                     end
                  end else begin
                     cnt_next = cnt + BW_ROW_INDEX'(1);
                  end
               end
            end
            DRAIN: begin
               if (cnt == ROW_LAST) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt + BW_ROW_INDEX'(1);
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   // Outputs. clear suppresses valid and the mreg shift in its cycle.
   always_comb begin
      storereg_wready         = (state == IDLE);
      busy                    = (state != IDLE);
      store_tensor_row_rvalid = (state == SEND) && enable && !clear;
      fire                    = store_tensor_row_rvalid && store_tensor_row_rready;
      mreg_move_renable       = fire || ((state == DRAIN) && enable && !clear);
      store_tensor_row_rlast  = store_tensor_row_rvalid && (cnt == num_m1);
      store_tensor_row_rdata  = store_tensor_row_rvalid ? head_masked : '0;
   end

endmodule

// File: tb/tb_dca_matrix_store_from_mreg.sv
module tb_dca_matrix_store_from_mreg;

   localparam logic [31:0] R0 = 32'h11111111;
   localparam logic [31:0] R1 = 32'h22222222;
   localparam logic [31:0] R2 = 32'h33333333;
   localparam logic [31:0] R3 = 32'h44444444;

   logic        clk = 1'b0;
   logic        rstnn = 1'b0;
   logic        clear = 1'b0;
   logic        enable = 1'b0;
   logic        busy;
   logic [1:0]  store_num_row_m1 = '0;
   logic        storereg_wrequest = 1'b0;
   logic        storereg_wready;
   logic        mreg_move_renable;
   logic [31:0] mreg_move_rdata_list1d;
   logic        store_tensor_row_rvalid;
   logic        store_tensor_row_rlast;
   logic [31:0] store_tensor_row_rdata;
   logic        store_tensor_row_rready = 1'b0;
`ifdef DCA_MATRIX_STORE_COL_MASK_EN
   logic [1:0]  store_num_col_m1 = 2'd3;
`endif

   int passed = 0;
   int total  = 0;

   // mreg model: four rows, head pointer advances on every pop
   logic [31:0] rows [4];
   logic [1:0]  ptr;
   assign mreg_move_rdata_list1d = rows[ptr];

   always_ff @(posedge clk or negedge rstnn) begin
      if (!rstnn) ptr <= '0;
      else if (mreg_move_renable) ptr <= ptr + 2'd1;
   end

   always #5 clk = ~clk;

   dca_matrix_store_from_mreg #(.MATRIX_SIZE_PARA(4), .TENSOR_PARA(0)) dut (
      .clk                     (clk),
      .rstnn                   (rstnn),
      .clear                   (clear),
      .enable                  (enable),
      .busy                    (busy),
      .store_num_row_m1        (store_num_row_m1),
`ifdef DCA_MATRIX_STORE_COL_MASK_EN
      .store_num_col_m1        (store_num_col_m1),
`endif
      .storereg_wrequest       (storereg_wrequest),
      .storereg_wready         (storereg_wready),
      .mreg_move_renable       (mreg_move_renable),
      .mreg_move_rdata_list1d  (mreg_move_rdata_list1d),
      .store_tensor_row_rvalid (store_tensor_row_rvalid),
      .store_tensor_row_rlast  (store_tensor_row_rlast),
      .store_tensor_row_rdata  (store_tensor_row_rdata),
      .store_tensor_row_rready (store_tensor_row_rready)
   );

   typedef struct {
      logic        clr, en, req;
      logic [1:0]  nrow;
      logic        rdy;
      logic        wr, bs, vl, ls, re;
      logic [31:0] d;
   } vec_t;

   function automatic vec_t v(logic clr, logic en, logic req, logic [1:0] nrow, logic rdy,
                              logic wr, logic bs, logic vl, logic ls, logic re, logic [31:0] d);
      vec_t t;
      t.clr = clr; t.en = en; t.req = req; t.nrow = nrow; t.rdy = rdy;
      t.wr = wr; t.bs = bs; t.vl = vl; t.ls = ls; t.re = re; t.d = d;
      return t;
   endfunction

   // {wready, busy, rvalid, rlast, renable, rdata}
   function automatic logic [36:0] outs();
      return {storereg_wready, busy, store_tensor_row_rvalid, store_tensor_row_rlast,
              mreg_move_renable, store_tensor_row_rdata};
   endfunction

   task automatic check(input string name, input logic [36:0] act, input logic [36:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s got=%h expected=%h", name, act, exp);
   endtask

   task automatic drive(input logic clr, input logic en, input logic req, input logic [1:0] nrow,
                        input logic rdy);
      @(posedge clk);
      #1;
      clear = clr; enable = en; storereg_wrequest = req;
      store_num_row_m1 = nrow; store_tensor_row_rready = rdy;
      @(negedge clk);
   endtask

   localparam int NV = 31;
   vec_t tv [NV];

   initial begin
      rows[0] = R0; rows[1] = R1; rows[2] = R2; rows[3] = R3;

      //              clr en req n rdy   wr bs vl ls re data
      // full matrix, num_row_m1=3
      tv[0]  = v(0, 1, 1, 3, 1,   1, 0, 0, 0, 0, '0);
      tv[1]  = v(0, 1, 0, 3, 1,   0, 1, 1, 0, 1, R0);
      tv[2]  = v(0, 1, 0, 3, 1,   0, 1, 1, 0, 1, R1);
      tv[3]  = v(0, 1, 0, 3, 1,   0, 1, 1, 0, 1, R2);
      tv[4]  = v(0, 1, 0, 3, 1,   0, 1, 1, 1, 1, R3);
      tv[5]  = v(0, 1, 0, 0, 1,   1, 0, 0, 0, 0, '0);
      // partial matrix, num_row_m1=1: two rows then two drain pops
      tv[6]  = v(0, 1, 1, 1, 1,   1, 0, 0, 0, 0, '0);
      tv[7]  = v(0, 1, 0, 1, 1,   0, 1, 1, 0, 1, R0);
      tv[8]  = v(0, 1, 0, 1, 1,   0, 1, 1, 1, 1, R1);
      tv[9]  = v(0, 1, 0, 1, 1,   0, 1, 0, 0, 1, '0);
      tv[10] = v(0, 1, 0, 1, 1,   0, 1, 0, 0, 1, '0);
      tv[11] = v(0, 1, 0, 0, 1,   1, 0, 0, 0, 0, '0);
      // backpressure 1,0,0,1; a wrequest during SEND is ignored
      tv[12] = v(0, 1, 1, 3, 1,   1, 0, 0, 0, 0, '0);
      tv[13] = v(0, 1, 0, 3, 1,   0, 1, 1, 0, 1, R0);
      tv[14] = v(0, 1, 1, 3, 0,   0, 1, 1, 0, 0, R1);
      tv[15] = v(0, 1, 1, 3, 0,   0, 1, 1, 0, 0, R1);
      tv[16] = v(0, 1, 0, 3, 1,   0, 1, 1, 0, 1, R1);
      tv[17] = v(0, 1, 0, 3, 1,   0, 1, 1, 0, 1, R2);
      tv[18] = v(0, 1, 0, 3, 1,   0, 1, 1, 1, 1, R3);
      tv[19] = v(0, 1, 0, 0, 1,   1, 0, 0, 0, 0, '0);
      // single row, enable low for 3 cycles mid-DRAIN
      tv[20] = v(0, 1, 1, 0, 1,   1, 0, 0, 0, 0, '0);
      tv[21] = v(0, 1, 0, 0, 1,   0, 1, 1, 1, 1, R0);
      tv[22] = v(0, 1, 0, 0, 1,   0, 1, 0, 0, 1, '0);
      tv[23] = v(0, 0, 0, 0, 1,   0, 1, 0, 0, 0, '0);
      tv[24] = v(0, 0, 0, 0, 1,   0, 1, 0, 0, 0, '0);
      tv[25] = v(0, 0, 0, 0, 1,   0, 1, 0, 0, 0, '0);
      tv[26] = v(0, 1, 0, 0, 1,   0, 1, 0, 0, 1, '0);
      tv[27] = v(0, 1, 0, 0, 1,   0, 1, 0, 0, 1, '0);
      tv[28] = v(0, 1, 0, 0, 1,   1, 0, 0, 0, 0, '0);
      // wrequest with enable low is not accepted
      tv[29] = v(0, 0, 1, 3, 1,   1, 0, 0, 0, 0, '0);
      tv[30] = v(0, 1, 0, 3, 1,   1, 0, 0, 0, 0, '0);

      // reset state
      repeat (2) @(negedge clk);
      check("reset", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
      rstnn = 1'b1;

      for (int i = 0; i < NV; i++) begin
         drive(tv[i].clr, tv[i].en, tv[i].req, tv[i].nrow, tv[i].rdy);
         check($sformatf("vec[%0d]", i), outs(),
               {tv[i].wr, tv[i].bs, tv[i].vl, tv[i].ls, tv[i].re, tv[i].d});
      end
      check("ptr_realigned", {35'd0, ptr}, 37'd0);

      // clear during SEND after one fire: abort, mreg left one row advanced
      drive(0, 1, 1, 3, 1);
      drive(0, 1, 0, 3, 1);
      check("clr_pre_fire", outs(), {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, R0});
      drive(1, 1, 0, 3, 1);
      check("clr_cycle", outs(), {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0});
      drive(0, 1, 0, 3, 1);
      check("clr_idle", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});
      check("clr_ptr", {35'd0, ptr}, 37'd1);
      // new matrix starts with cnt=0 from the unrealigned head
      drive(0, 1, 1, 3, 1);
      drive(0, 1, 0, 3, 1);
      check("post_clr_r0", outs(), {1'b0, 1'b1, 1'b1, 1'b0, 1'b1, R1});
      drive(0, 1, 0, 3, 1);
      drive(0, 1, 0, 3, 1);
      drive(0, 1, 0, 3, 1);
      check("post_clr_last", outs(), {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, R0});
      drive(0, 1, 0, 3, 1);
      check("post_clr_idle", outs(), {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0});

`ifdef DCA_MATRIX_STORE_COL_MASK_EN
      for (int r = 0; r < 4; r++) rows[r] = 32'h44332211;
      store_num_col_m1 = 2'd1;
      drive(0, 1, 1, 0, 1);
      drive(0, 1, 0, 0, 1);
      check("col_mask", outs(), {1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h00002211});
      drive(0, 1, 0, 0, 1);
      check("col_mask_drain", outs(), {1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0});
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
